// File: rtl/ram_mr1w.sv
// ram_mr1w: multi-read, single-write synchronous RAM with registered reads, priority debug port,
// optional write-first bypass and an optional post-reset clear sweep.
module ram_mr1w #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ = 3,
    parameter int BYPASS = 0,
    parameter int CLEAR_ON_RESET = 0,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*WIDTH-1:0]      rdata,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           wen,
    input  logic [ADDR_WIDTH-1:0]          debug_write_addr,
    input  logic [WIDTH-1:0]               debug_write_data,
    input  logic                           debug_write_en,
    input  logic [ADDR_WIDTH-1:0]          debug_addr,
    output logic [WIDTH-1:0]               debug_data,
    output logic                           ready
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, next_state;
    logic [ADDR_WIDTH-1:0] cptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ+1];
    logic [WIDTH-1:0] rd_next [NUM_READ+1];
    logic dbg_ok, fn_ok, sweep, last;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < (ADDR_WIDTH+1)'(DEPTH);
    endfunction

    assign sweep = state == CLEAR && !rst;
    assign last = cptr == ADDR_WIDTH'(DEPTH - 1);
    // Debug writes stay live through reset so operands can be preloaded before release.
    assign dbg_ok = state == RUN && debug_write_en && in_range(debug_write_addr);
    assign fn_ok = state == RUN && !rst && wen && in_range(waddr)
                   && !(dbg_ok && waddr == debug_write_addr);

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
        else state <= next_state;
    end

    always_comb begin
        next_state = state == CLEAR && last ? RUN : state;
    end

    assign ready = state == RUN;

    always_ff @(posedge clk) begin
        if (rst) cptr <= '0;
        else if (state == CLEAR) cptr <= cptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (sweep) mem[cptr] <= CLEAR_VALUE;
        else begin
            if (dbg_ok) mem[debug_write_addr] <= debug_write_data;
            if (fn_ok) mem[waddr] <= wdata;
        end
    end

    // Slot NUM_READ is the debug read port; it shares the functional read path.
    always_comb begin
        for (int k = 0; k < NUM_READ; k++) rd_addr[k] = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        rd_addr[NUM_READ] = debug_addr;
        for (int k = 0; k <= NUM_READ; k++)
            rd_next[k] = !in_range(rd_addr[k]) ? '0
                       : BYPASS != 0 && dbg_ok && debug_write_addr == rd_addr[k] ? debug_write_data
                       : BYPASS != 0 && fn_ok && waddr == rd_addr[k] ? wdata
                       : mem[rd_addr[k]];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_READ; k++)
            rdata[k*WIDTH +: WIDTH] <= rst || state == CLEAR ? '0 : rd_next[k];
        debug_data <= rst || state == CLEAR ? '0 : rd_next[NUM_READ];
    end
endmodule
